instruction_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of InstructionMemoryModule. Holds the program counter and drives InstructionAddress.

---
 rtl/instruction_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch stage sitting directly in front of the instruction memory. It holds the
//   PC and drives InstructionAddress from it. The memory returns Instruction in the
//   same cycle. Each {PC, Instruction} pair is pushed into a small FIFO, and decode
//   drains the FIFO through a valid/ready handshake. Execute can redirect the PC,
//   and a redirect flushes the FIFO.
//
// Parameters
//   RESET_VECTOR  PC value while in reset and just after it
//   BUFFER_DEPTH  number of FIFO entries (a power of 2, at least 2)
//   PC_INCREMENT  step added to the PC after each sequential fetch, in bytes
//
// Ports
//   Clock              rising-edge clock
//   ResetN             asynchronous reset, active low
//   InstructionAddress out: address sent to the instruction memory (the PC register)
//   Instruction        in:  word the memory returns for InstructionAddress
//   RedirectValid      in:  execute asks for a PC change in this cycle
//   RedirectTarget     in:  the new PC
//   FetchValid         out: the FIFO head entry is valid toward decode
//   FetchReady         in:  decode accepts the head entry
//   FetchInstruction   out: instruction held in the head entry
//   FetchPC            out: PC held in the head entry
//   MisalignTrap       out: only present when FETCH_MISALIGN_TRAP_EN is defined
//
// Optional feature: FETCH_MISALIGN_TRAP_EN
//   When this macro is defined, a redirect to an address that is not word aligned
//   flushes the FIFO, leaves the PC unchanged and enters TRAP. A later aligned
//   redirect leaves TRAP. When the macro is not defined, the low two bits of the
//   target are dropped and the FSM only ever uses RUN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned BUFFER_DEPTH = 2,
    parameter logic [31:0] PC_INCREMENT = 32'd4
) (
    input  logic        Clock,
    input  logic        ResetN,
    output logic [31:0] InstructionAddress,
    input  logic [31:0] Instruction,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    output logic        FetchValid,
    input  logic        FetchReady,
    output logic [31:0] FetchInstruction,
    output logic [31:0] FetchPC
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        MisalignTrap
`endif
);

    localparam int unsigned PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;

    typedef enum logic {
        RUN,
        TRAP
    } state_t;

    state_t             state;
    logic [31:0]        pc;
    logic [31:0]        fifo_pc    [BUFFER_DEPTH];
    logic [31:0]        fifo_instr [BUFFER_DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W:0]     count;

    logic               full;
    logic               pop;
    logic               push;
    logic               target_ok;
    logic [31:0]        target_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic               trap_q;

    assign target_ok = (RedirectTarget[1:0] == 2'b00);
    assign target_pc = RedirectTarget;
    assign MisalignTrap = trap_q;
`else
    logic               unused_target_lsbs;

    assign unused_target_lsbs = ^RedirectTarget[1:0];
    assign target_ok = 1'b1;
    assign target_pc = {RedirectTarget[31:2], 2'b00};
`endif

    assign InstructionAddress = pc;
    assign full               = (count == (PTR_W+1)'(BUFFER_DEPTH));

    // While in TRAP the FIFO is always empty, so no separate state term is needed here.
    // The redirect term kills the output combinationally, so a redirect cycle can
    // never complete a handshake.
    assign FetchValid       = (count != '0) & !RedirectValid;
    assign pop              = FetchValid & FetchReady;
    assign push             = !RedirectValid & (state == RUN) & (!full | pop);
    assign FetchPC          = fifo_pc[head];
    assign FetchInstruction = fifo_instr[head];

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state <= RUN;
            pc    <= RESET_VECTOR;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < BUFFER_DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q <= 1'b0;
`endif
        end else if (RedirectValid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            if (target_ok) begin
                pc    <= target_pc;
                state <= RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
                trap_q <= 1'b0;
`endif
            end else begin
                // A misaligned target leaves the PC as it is and parks the unit in TRAP.
                state <= TRAP;
`ifdef FETCH_MISALIGN_TRAP_EN
                trap_q <= 1'b1;
`endif
            end
        end else begin
            if (push) begin
                fifo_pc[tail]    <= pc;
                fifo_instr[tail] <= Instruction;
                tail             <= tail + 1'b1;
                pc               <= pc + PC_INCREMENT;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit.
// The reference model is a queue of fetched PCs plus a scalar PC. The memory
// returns PC ^ 32'hA5A5_0000, so each instruction can be recomputed from its PC.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam int          DEPTH        = 2;
    localparam logic [31:0] MAGIC        = 32'hA5A5_0000;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic [31:0] InstructionAddress;
    logic [31:0] Instruction;
    logic        RedirectValid;
    logic [31:0] RedirectTarget;
    logic        FetchValid;
    logic        FetchReady;
    logic [31:0] FetchInstruction;
    logic [31:0] FetchPC;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        MisalignTrap;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] mq[$];
    logic [31:0] mpc;
    logic        mtrap;

    always #5 Clock = ~Clock;

    assign Instruction = InstructionAddress ^ MAGIC;

    instruction_fetch_unit #(
        .RESET_VECTOR(RESET_VECTOR),
        .BUFFER_DEPTH(DEPTH),
        .PC_INCREMENT(32'd4)
    ) dut (
        .Clock             (Clock),
        .ResetN            (ResetN),
        .InstructionAddress(InstructionAddress),
        .Instruction       (Instruction),
        .RedirectValid     (RedirectValid),
        .RedirectTarget    (RedirectTarget),
        .FetchValid        (FetchValid),
        .FetchReady        (FetchReady),
        .FetchInstruction  (FetchInstruction),
        .FetchPC           (FetchPC)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .MisalignTrap      (MisalignTrap)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc   = RESET_VECTOR;
        mtrap = 1'b0;
    endtask

    // Call this 1 time unit after a rising edge. It drives the inputs, checks the
    // DUT against the model mid-cycle, updates the model, and then moves on to the
    // next edge plus 1.
    task automatic step(input logic rv, input logic [31:0] rt, input logic rdy);
        logic exp_valid;
        logic pop;
        logic push;
        RedirectValid  = rv;
        RedirectTarget = rt;
        FetchReady     = rdy;
        #3;
        exp_valid = (mq.size() != 0) && !rv;
        chk("FetchValid", {31'b0, FetchValid}, {31'b0, exp_valid});
        chk("InstructionAddress", InstructionAddress, mpc);
        if (exp_valid) begin
            chk("FetchPC", FetchPC, mq[0]);
            chk("FetchInstruction", FetchInstruction, mq[0] ^ MAGIC);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("MisalignTrap", {31'b0, MisalignTrap}, {31'b0, mtrap});
`endif
        if (rv) begin
            mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            if (rt[1:0] != 2'b00) begin
                mtrap = 1'b1;
            end else begin
                mpc   = rt;
                mtrap = 1'b0;
            end
`else
            mpc = {rt[31:2], 2'b00};
`endif
        end else begin
            pop  = exp_valid && rdy;
            push = !mtrap && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(mpc);
                mpc = mpc + 32'd4;
            end
        end
        @(posedge Clock);
        #1;
    endtask

    initial begin
        ResetN         = 1'b0;
        RedirectValid  = 1'b0;
        RedirectTarget = '0;
        FetchReady     = 1'b0;
        model_reset();
        #2;
        chk("reset_valid", {31'b0, FetchValid}, 32'd0);
        chk("reset_pc", FetchPC, 32'h0);
        chk("reset_instr", FetchInstruction, 32'h0);
        chk("reset_addr", InstructionAddress, RESET_VECTOR);
        @(posedge Clock);
        #1;
        ResetN = 1'b1;

        // 1: streaming with FetchReady held high
        step(1'b0, '0, 1'b1);
        chk("t1_first_valid", {31'b0, FetchValid}, 32'd1);
        chk("t1_first_pc", FetchPC, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        chk("t1_fourth_pc", FetchPC, 32'hC);
        chk("t1_fourth_instr", FetchInstruction, 32'hA5A5_000C);

        // 2: stall for 5 cycles, then drain with no gap and no duplicate
        step(1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
        chk("t2_hold_addr", InstructionAddress, 32'h8);
        chk("t2_hold_pc", FetchPC, 32'h0);
        step(1'b0, '0, 1'b1);
        chk("t2_drain1", FetchPC, 32'h4);
        step(1'b0, '0, 1'b1);
        chk("t2_drain2", FetchPC, 32'h8);

        // 3: redirect while the FIFO is full and decode is ready
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        step(1'b1, 32'h100, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("t3_target_valid", {31'b0, FetchValid}, 32'd1);
        chk("t3_target_pc", FetchPC, 32'h100);

        // 4: the PC wraps around at the top of the address space
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("t4_top", FetchPC, 32'hFFFF_FFFC);
        step(1'b0, '0, 1'b1);
        chk("t4_wrap", FetchPC, 32'h0);

        // 5: asynchronous reset asserted between clock edges in the middle of a stream
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        RedirectValid = 1'b0;
        #2;
        ResetN = 1'b0;
        #1;
        chk("t5_async_valid", {31'b0, FetchValid}, 32'd0);
        chk("t5_async_addr", InstructionAddress, RESET_VECTOR);
        model_reset();
        @(posedge Clock);
        #1;
        ResetN = 1'b1;
        step(1'b0, '0, 1'b1);
        chk("t5_restart", FetchPC, 32'h0);

        // 6: redirect to a misaligned target
`ifdef FETCH_MISALIGN_TRAP_EN
        step(1'b1, 32'h102, 1'b1);
        chk("t6_trap_set", {31'b0, MisalignTrap}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 32'h200, 1'b1);
        chk("t6_trap_clear", {31'b0, MisalignTrap}, 32'd0);
        step(1'b0, '0, 1'b1);
        chk("t6_target_pc", FetchPC, 32'h200);
`else
        step(1'b1, 32'h102, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("t6_aligned_pc", FetchPC, 32'h100);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        rv;
            logic [31:0] rt;
            rv = ($urandom_range(0, 11) == 0);
            rt = $urandom();
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            step(rv, rt, ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
